// File: rtl/scr1_axi_tb_pkg.sv
// scr1_axi_tb_pkg
//   Shared types and constants for the single-outstanding AXI4 bench initiator:
//   FSM state encoding, AXI response codes, burst type and a response check.
package scr1_axi_tb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_WR_RESP,
        ST_RD_REQ,
        ST_RD_DATA,
        ST_RSP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] BURST_INCR  = 2'b01;

    // Anything other than OKAY (including EXOKAY, which a single-beat
    // non-exclusive access should never see) is reported as an error.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp != RESP_OKAY;
    endfunction

endpackage

// File: rtl/scr1_axi_tb_wdog.sv
// scr1_axi_tb_wdog
//   Saturating transaction watchdog with a sticky expiry flag.
//   clk, rst  : clock, asynchronous active-high reset
//   clr       : zero the counter (flag is untouched)
//   en        : count one cycle; stops at TIMEOUT
//   expired   : sticky, set in the cycle the count reaches TIMEOUT, cleared by rst only
module scr1_axi_tb_wdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned         CW    = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]       LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          expired_q, expired_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CW'(1);
        end
        // Flag follows the next count so it rises on the same edge the
        // counter reaches the limit.
        expired_d = expired_q | (cnt_d == LIMIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= expired_d;
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/scr1_axi_tb_master.sv
// scr1_axi_tb_master
//   Single-outstanding AXI4 initiator: turns one req_* command into one
//   single-beat INCR transaction and reports the outcome on rsp_*.
//   req_valid/req_ready/req_we/req_addr/req_size/req_wdata/req_wstrb : command in
//   rsp_valid/rsp_ready/rsp_rdata/rsp_resp/rsp_err                    : result out
//   timeout : sticky, a transaction sat on the bus for TIMEOUT cycles
//   aw*/w*/b*/ar*/r* : AXI4 master channels (len 0, id = ID)
module scr1_axi_tb_master
    import scr1_axi_tb_pkg::*;
#(
    parameter int unsigned W_ID    = 4,
    parameter int unsigned W_ADR   = 32,
    parameter int unsigned W_DATA  = 32,
    parameter int unsigned ID      = 0,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic                clk,
    input  logic                rst,
    // command port
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [W_ADR-1:0]    req_addr,
    input  logic [2:0]          req_size,
    input  logic [W_DATA-1:0]   req_wdata,
    input  logic [W_DATA/8-1:0] req_wstrb,
    // response port
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [W_DATA-1:0]   rsp_rdata,
    output logic [1:0]          rsp_resp,
    output logic                rsp_err,
    output logic                timeout,
    // AW
    output logic                awvalid,
    output logic [W_ID-1:0]     awid,
    output logic [W_ADR-1:0]    awaddr,
    output logic [2:0]          awsize,
    output logic [7:0]          awlen,
    input  logic                awready,
    // W
    output logic                wvalid,
    output logic [W_DATA-1:0]   wdata,
    output logic [W_DATA/8-1:0] wstrb,
    output logic                wlast,
    input  logic                wready,
    // B
    input  logic                bvalid,
    input  logic [W_ID-1:0]     bid,
    input  logic [1:0]          bresp,
    output logic                bready,
    // AR
    output logic                arvalid,
    output logic [W_ID-1:0]     arid,
    output logic [W_ADR-1:0]    araddr,
    output logic [1:0]          arburst,
    output logic [2:0]          arsize,
    output logic [7:0]          arlen,
    input  logic                arready,
    // R
    input  logic                rvalid,
    input  logic [W_ID-1:0]     rid,
    input  logic [W_DATA-1:0]   rdata,
    input  logic                rlast,
    input  logic [1:0]          rresp,
    output logic                rready
);

    localparam int unsigned    W_STRB = W_DATA / 8;
    localparam logic [W_ID-1:0] ID_V  = W_ID'(ID);

    state_e              state_q, state_d;
    logic [W_ADR-1:0]    addr_q, addr_d;
    logic [2:0]          size_q, size_d;
    logic [W_DATA-1:0]   wdata_q, wdata_d;
    logic [W_STRB-1:0]   wstrb_q, wstrb_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [W_DATA-1:0]   rdata_q, rdata_d;
    logic [1:0]          resp_q, resp_d;
    logic                err_q, err_d;

    logic aw_hs, w_hs, b_hs, r_hs;
    logic wdog_clr, wdog_en;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (req_valid) state_d = req_we ? ST_WR_REQ : ST_RD_REQ;
            // AW and W may complete in either order or together.
            ST_WR_REQ:  if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_WR_RESP;
            ST_WR_RESP: if (bvalid)    state_d = ST_RSP;
            ST_RD_REQ:  if (arready)   state_d = ST_RD_DATA;
            ST_RD_DATA: if (rvalid)    state_d = ST_RSP;
            ST_RSP:     if (rsp_ready) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        req_ready = (state_q == ST_IDLE);
        awvalid   = (state_q == ST_WR_REQ) && !aw_done_q;
        wvalid    = (state_q == ST_WR_REQ) && !w_done_q;
        bready    = (state_q == ST_WR_RESP);
        arvalid   = (state_q == ST_RD_REQ);
        rready    = (state_q == ST_RD_DATA);
        rsp_valid = (state_q == ST_RSP);
        wdog_clr  = (state_q == ST_IDLE);
        wdog_en   = (state_q == ST_WR_REQ) || (state_q == ST_WR_RESP) ||
                    (state_q == ST_RD_REQ) || (state_q == ST_RD_DATA);
    end

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid  && wready;
    assign b_hs  = bready  && bvalid;
    assign r_hs  = rready  && rvalid;

    // ---------------- command / result datapath ----------------
    always_comb begin
        addr_d    = addr_q;
        size_d    = size_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        rdata_d   = rdata_q;
        resp_d    = resp_q;
        err_d     = err_q;

        if ((state_q == ST_IDLE) && req_valid) begin
            addr_d    = req_addr;
            size_d    = req_size;
            wdata_d   = req_wdata;
            wstrb_d   = req_wstrb;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            // Clearing here makes rsp_rdata read as zero for writes.
            rdata_d   = '0;
            resp_d    = RESP_OKAY;
            err_d     = 1'b0;
        end

        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;

        if (b_hs) begin
            resp_d = bresp;
            err_d  = (bid != ID_V) || resp_is_err(bresp);
        end

        if (r_hs) begin
            rdata_d = rdata;
            resp_d  = rresp;
            err_d   = (rid != ID_V) || !rlast || resp_is_err(rresp);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q    <= '0;
            size_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            rdata_q   <= '0;
            resp_q    <= RESP_OKAY;
            err_q     <= 1'b0;
        end else begin
            addr_q    <= addr_d;
            size_q    <= size_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            rdata_q   <= rdata_d;
            resp_q    <= resp_d;
            err_q     <= err_d;
        end
    end

    // ---------------- watchdog ----------------
    scr1_axi_tb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wdog_clr),
        .en      (wdog_en),
        .expired (timeout)
    );

    // ---------------- constant / registered AXI fields ----------------
    assign awid      = ID_V;
    assign awaddr    = addr_q;
    assign awsize    = size_q;
    assign awlen     = 8'd0;
    assign wdata     = wdata_q;
    assign wstrb     = wstrb_q;
    assign wlast     = wvalid;
    assign arid      = ID_V;
    assign araddr    = addr_q;
    assign arburst   = BURST_INCR;
    assign arsize    = size_q;
    assign arlen     = 8'd0;
    assign rsp_rdata = rdata_q;
    assign rsp_resp  = resp_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_scr1_axi_tb_master.sv
module tb_scr1_axi_tb_master;

    localparam int          TMO  = 16;
    localparam logic [3:0]  TID  = 4'd3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_size;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err, timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        awvalid, awready, wvalid, wready, wlast, bvalid, bready;
    logic        arvalid, arready, rvalid, rready, rlast;
    logic [3:0]  awid, arid, bid, rid, wstrb;
    logic [31:0] awaddr, araddr, wdata, rdata;
    logic [2:0]  awsize, arsize;
    logic [7:0]  awlen, arlen;
    logic [1:0]  arburst, bresp, rresp;

    always #5 clk = ~clk;

    scr1_axi_tb_master #(
        .W_ID(4), .W_ADR(32), .W_DATA(32), .ID(3), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_err(rsp_err), .timeout(timeout),
        .awvalid(awvalid), .awid(awid), .awaddr(awaddr), .awsize(awsize), .awlen(awlen), .awready(awready),
        .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wready(wready),
        .bvalid(bvalid), .bid(bid), .bresp(bresp), .bready(bready),
        .arvalid(arvalid), .arid(arid), .araddr(araddr), .arburst(arburst), .arsize(arsize),
        .arlen(arlen), .arready(arready),
        .rvalid(rvalid), .rid(rid), .rdata(rdata), .rlast(rlast), .rresp(rresp), .rready(rready)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural AXI slave ----------------
    // Knobs: cycles each valid must be seen before ready/valid is returned.
    int          k_aw_lat, k_w_lat, k_b_lat, k_ar_lat, k_r_lat;
    logic [3:0]  k_bid, k_rid;
    logic [1:0]  k_bresp, k_rresp;
    logic        k_rlast;

    logic [31:0] smem [int unsigned];
    int          aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    logic        got_aw, got_w, b_pend, r_pend;
    logic        p_awv, p_wv, p_arv, p_bready, p_rready;
    logic [31:0] p_awaddr, p_wdata, p_araddr, s_awaddr, s_wdata, s_araddr;
    logic [3:0]  p_wstrb, s_wstrb;

    task automatic knobs_default();
        k_aw_lat = 0; k_w_lat = 0; k_b_lat = 0; k_ar_lat = 0; k_r_lat = 0;
        k_bid = TID; k_rid = TID; k_bresp = 2'b00; k_rresp = 2'b00; k_rlast = 1'b1;
    endtask

    initial begin : slave
        logic [31:0] word;
        forever begin
            @(negedge clk);
            if (rst) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                bid = 0; bresp = 0; rid = 0; rdata = 0; rlast = 0; rresp = 0;
                aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
                got_aw = 0; got_w = 0; b_pend = 0; r_pend = 0;
                p_awv = 0; p_wv = 0; p_arv = 0; p_bready = 0; p_rready = 0;
            end else begin
                // handshakes that completed on the edge just passed
                if (p_awv && awready) begin got_aw = 1; s_awaddr = p_awaddr; end
                if (p_wv && wready) begin got_w = 1; s_wdata = p_wdata; s_wstrb = p_wstrb; end
                if (bvalid && p_bready) bvalid = 0;
                if (p_arv && arready) begin r_pend = 1; r_cnt = 0; s_araddr = p_araddr; end
                if (rvalid && p_rready) rvalid = 0;
                if (got_aw && got_w) begin
                    word = smem.exists(s_awaddr >> 2) ? smem[s_awaddr >> 2] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (s_wstrb[b]) word[8*b +: 8] = s_wdata[8*b +: 8];
                    smem[s_awaddr >> 2] = word;
                    got_aw = 0; got_w = 0; b_pend = 1; b_cnt = 0;
                end
                p_awv = awvalid; p_awaddr = awaddr; p_wv = wvalid; p_wdata = wdata; p_wstrb = wstrb;
                p_arv = arvalid; p_araddr = araddr; p_bready = bready; p_rready = rready;
                awready = awvalid && (aw_cnt >= k_aw_lat); aw_cnt = awvalid ? aw_cnt + 1 : 0;
                wready  = wvalid  && (w_cnt  >= k_w_lat);  w_cnt  = wvalid  ? w_cnt + 1  : 0;
                arready = arvalid && (ar_cnt >= k_ar_lat); ar_cnt = arvalid ? ar_cnt + 1 : 0;
                if (b_pend && !bvalid) begin
                    if (b_cnt >= k_b_lat) begin
                        bvalid = 1; bid = k_bid; bresp = k_bresp; b_pend = 0;
                    end else b_cnt++;
                end
                if (r_pend && !rvalid) begin
                    if (r_cnt >= k_r_lat) begin
                        rvalid = 1; rid = k_rid; rresp = k_rresp; rlast = k_rlast; r_pend = 0;
                        rdata = smem.exists(s_araddr >> 2) ? smem[s_araddr >> 2] : 32'h0;
                    end else r_cnt++;
                end
            end
        end
    end

    // ---------------- vectors ----------------
    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          aw_lat, w_lat, b_lat, ar_lat, r_lat, hold;
        logic [3:0]  bid, rid;
        logic [1:0]  bresp, rresp;
        logic        rlast;
        logic [31:0] exp_rdata;
        logic [1:0]  exp_resp;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    function automatic vec_t base();
        vec_t v;
        v.we = 0; v.addr = 0; v.size = 2; v.wdata = 0; v.wstrb = 0;
        v.aw_lat = 0; v.w_lat = 0; v.b_lat = 0; v.ar_lat = 0; v.r_lat = 0; v.hold = 0;
        v.bid = TID; v.rid = TID; v.bresp = 0; v.rresp = 0; v.rlast = 1;
        v.exp_rdata = 0; v.exp_resp = 0; v.exp_err = 0; v.exp_lat = 2;
        return v;
    endfunction

    function automatic vec_t mkw(logic [31:0] a, logic [2:0] s, logic [31:0] d, logic [3:0] st,
                                 int awl, int wl, int bl, logic [3:0] bi, logic [1:0] br,
                                 logic [1:0] er, logic ee, int el);
        vec_t v = base();
        v.we = 1; v.addr = a; v.size = s; v.wdata = d; v.wstrb = st;
        v.aw_lat = awl; v.w_lat = wl; v.b_lat = bl; v.bid = bi; v.bresp = br;
        v.exp_resp = er; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    function automatic vec_t mkr(logic [31:0] a, logic [2:0] s, int arl, int rl, logic [3:0] ri,
                                 logic [1:0] rr, logic rla, logic [31:0] ed, logic [1:0] er,
                                 logic ee, int el);
        vec_t v = base();
        v.addr = a; v.size = s; v.ar_lat = arl; v.r_lat = rl; v.rid = ri; v.rresp = rr;
        v.rlast = rla; v.exp_rdata = ed; v.exp_resp = er; v.exp_err = ee; v.exp_lat = el;
        return v;
    endfunction

    logic exp_to = 1'b0;

    task automatic run_txn(input string tag, input vec_t v);
        int   k, n;
        logic got, bad, hold_bad, aw_seen, w_seen, ar_seen;
        logic [31:0] c_rdata;
        logic [1:0]  c_resp;
        logic        c_err;
        k_aw_lat = v.aw_lat; k_w_lat = v.w_lat; k_b_lat = v.b_lat;
        k_ar_lat = v.ar_lat; k_r_lat = v.r_lat;
        k_bid = v.bid; k_rid = v.rid; k_bresp = v.bresp; k_rresp = v.rresp; k_rlast = v.rlast;
        @(negedge clk); #1;
        req_valid = 1; req_we = v.we; req_addr = v.addr; req_size = v.size;
        req_wdata = v.wdata; req_wstrb = v.wstrb; rsp_ready = 0;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
        chk({tag, " req_ready"}, 32'(req_ready), 32'd1);
        @(negedge clk); #1;
        req_valid = 0;
        k = 0; got = 0; bad = 0; aw_seen = 0; w_seen = 0; ar_seen = 0;
        chk({tag, " issue"}, {29'd0, awvalid, wvalid, arvalid}, v.we ? 32'd6 : 32'd1);
        while (k < 200) begin
            if (aw_seen && awvalid) bad = 1;
            if (w_seen && wvalid) bad = 1;
            if (ar_seen && arvalid) bad = 1;
            if (bready && !(aw_seen && w_seen)) bad = 1;
            if (rready && !ar_seen) bad = 1;
            if (awvalid && (awaddr !== v.addr || awsize !== v.size || awid !== TID)) bad = 1;
            if (wvalid && (wdata !== v.wdata || wstrb !== v.wstrb)) bad = 1;
            if (arvalid && (araddr !== v.addr || arsize !== v.size || arid !== TID)) bad = 1;
            if (wlast !== wvalid || awlen !== 8'd0 || arlen !== 8'd0 || arburst !== 2'b01) bad = 1;
            if (v.we && (arvalid || rready)) bad = 1;
            if (!v.we && (awvalid || wvalid || bready)) bad = 1;
            if (rsp_valid) begin got = 1; break; end
            aw_seen |= awvalid && awready;
            w_seen  |= wvalid && wready;
            ar_seen |= arvalid && arready;
            @(negedge clk); #1; k++;
        end
        chk({tag, " rsp_valid"}, 32'(got), 32'd1);
        chk({tag, " latency"}, 32'(k), 32'(v.exp_lat));
        chk({tag, " protocol"}, 32'(bad), 32'd0);
        c_rdata = rsp_rdata; c_resp = rsp_resp; c_err = rsp_err;
        hold_bad = 0;
        for (int h = 0; h < v.hold; h++) begin
            @(negedge clk); #1;
            if (rsp_valid !== 1'b1 || rsp_rdata !== c_rdata || rsp_resp !== c_resp || rsp_err !== c_err)
                hold_bad = 1;
        end
        if (v.hold > 0) chk({tag, " hold"}, 32'(hold_bad), 32'd0);
        chk({tag, " rdata"}, rsp_rdata, v.we ? 32'd0 : v.exp_rdata);
        chk({tag, " resp"}, 32'(rsp_resp), 32'(v.exp_resp));
        chk({tag, " err"}, 32'(rsp_err), 32'(v.exp_err));
        rsp_ready = 1;
        @(negedge clk); #1;
        rsp_ready = 0;
        chk({tag, " back to idle"}, {30'd0, rsp_valid, req_ready}, 32'd1);
        chk({tag, " timeout"}, 32'(timeout), 32'(exp_to));
    endtask

    // ---------------- reference model for random traffic ----------------
    logic [31:0] ref_mem [int unsigned];

    vec_t tbl[10];

    initial begin : watchdog
        #400000;
        $display("FAIL global time limit: got running expected finished");
        $fatal(1, "time limit");
    end

    initial begin : main
        vec_t v;
        int   n, nb, off, w;
        logic [31:0] word;
        logic [3:0]  st;

        req_valid = 0; req_we = 0; req_addr = 0; req_size = 0; req_wdata = 0; req_wstrb = 0;
        rsp_ready = 0;
        knobs_default();

        tbl[0] = mkw(32'h100, 2, 32'hDEADBEEF, 4'hF, 0, 0, 0, TID, 2'b00, 2'b00, 0, 2);
        tbl[1] = mkr(32'h100, 2, 0, 0, TID, 2'b00, 1, 32'hDEADBEEF, 2'b00, 0, 2);
        tbl[2] = mkw(32'h104, 2, 32'h11223344, 4'h5, 3, 0, 0, TID, 2'b00, 2'b00, 0, 5);
        tbl[3] = mkr(32'h104, 2, 0, 0, TID, 2'b00, 1, 32'h00220044, 2'b00, 0, 2);
        tbl[4] = mkw(32'h108, 2, 32'hCAFEF00D, 4'hF, 0, 2, 1, TID + 4'd1, 2'b00, 2'b00, 1, 5);
        tbl[5] = mkw(32'h10C, 1, 32'h0000ABCD, 4'h3, 0, 0, 0, TID, 2'b10, 2'b10, 1, 2);
        tbl[6] = mkr(32'h108, 2, 1, 2, TID, 2'b10, 1, 32'hCAFEF00D, 2'b10, 1, 5);
        tbl[7] = mkr(32'h10C, 2, 0, 0, TID, 2'b00, 0, 32'h0000ABCD, 2'b00, 1, 2);
        tbl[8] = mkr(32'h100, 2, 0, 0, TID + 4'd2, 2'b00, 1, 32'hDEADBEEF, 2'b00, 1, 2);
        tbl[9] = mkr(32'h104, 0, 0, 0, TID, 2'b11, 1, 32'h00220044, 2'b11, 1, 2);
        tbl[4].hold = 1;
        tbl[9].hold = 2;

        // reset state
        #1;
        chk("reset valids", {25'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid, timeout}, 32'd0);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset regs", awaddr | wdata | rsp_rdata | araddr, 32'd0);
        repeat (3) @(negedge clk);
        #1 rst = 0;

        for (int i = 0; i < 10; i++) run_txn($sformatf("vec%0d", i), tbl[i]);

        // randomized traffic over a small window
        for (int i = 0; i < 40; i++) begin
            w = 32'h80 + $urandom_range(0, 3);
            if ($urandom_range(0, 1) == 1) begin
                nb  = 1 << $urandom_range(0, 2);
                off = ($urandom_range(0, 3) / nb) * nb;
                st  = 4'(((1 << nb) - 1) << off);
                v = mkw(32'(w * 4 + off), 3'($clog2(nb)), $urandom, st,
                        $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                        TID, 2'b00, 2'b00, 0, 0);
                v.exp_lat = 2 + ((v.aw_lat > v.w_lat) ? v.aw_lat : v.w_lat) + v.b_lat;
                word = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
                for (int b = 0; b < 4; b++) if (st[b]) word[8*b +: 8] = v.wdata[8*b +: 8];
                ref_mem[w] = word;
            end else begin
                v = mkr(32'(w * 4), 2, $urandom_range(0, 3), $urandom_range(0, 3), TID, 2'b00, 1,
                        ref_mem.exists(w) ? ref_mem[w] : 32'h0, 2'b00, 0, 0);
                v.exp_lat = 2 + v.ar_lat + v.r_lat;
            end
            v.hold = $urandom_range(0, 2);
            run_txn($sformatf("rnd%0d", i), v);
        end

        // timeout: arready withheld, then released
        knobs_default();
        k_ar_lat = 100000;
        @(negedge clk); #1;
        req_valid = 1; req_we = 0; req_addr = 32'h100; req_size = 2; rsp_ready = 0;
        chk("tmo req_ready", 32'(req_ready), 32'd1);
        @(negedge clk); #1;
        req_valid = 0;
        chk("tmo arvalid rise", 32'(arvalid), 32'd1);
        for (int k = 1; k <= TMO; k++) begin
            @(negedge clk); #1;
            if (k == TMO - 1) chk("tmo before limit", 32'(timeout), 32'd0);
            if (k == TMO) chk("tmo at limit", {30'd0, timeout, arvalid}, 32'd3);
        end
        k_ar_lat = 0;
        n = 0;
        while (!rsp_valid && n < 20) begin @(negedge clk); #1; n++; end
        chk("tmo rsp_valid", 32'(rsp_valid), 32'd1);
        chk("tmo rdata", rsp_rdata, 32'hDEADBEEF);
        chk("tmo resp/err", {29'd0, rsp_resp, rsp_err}, 32'd0);
        chk("tmo sticky", 32'(timeout), 32'd1);
        rsp_ready = 1;
        @(negedge clk); #1;
        rsp_ready = 0;

        // reset pulse while waiting for B
        knobs_default();
        k_b_lat = 50;
        @(negedge clk); #1;
        req_valid = 1; req_we = 1; req_addr = 32'h300; req_size = 2;
        req_wdata = 32'h5A5A5A5A; req_wstrb = 4'hF;
        @(negedge clk); #1;
        req_valid = 0;
        n = 0;
        while (!bready && n < 20) begin @(negedge clk); #1; n++; end
        chk("rst bready reached", 32'(bready), 32'd1);
        rst = 1;
        #1;
        chk("rst valids", {26'd0, awvalid, wvalid, arvalid, bready, rready, rsp_valid}, 32'd0);
        chk("rst req_ready/timeout", {30'd0, req_ready, timeout}, 32'd2);
        @(negedge clk);
        @(negedge clk); #2;
        knobs_default();
        rst = 0;
        exp_to = 0;
        run_txn("post-rst wr", mkw(32'h304, 2, 32'h0BADCAFE, 4'hF, 0, 0, 0, TID, 2'b00, 2'b00, 0, 2));
        run_txn("post-rst rd", mkr(32'h304, 2, 0, 0, TID, 2'b00, 1, 32'h0BADCAFE, 2'b00, 0, 2));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/scr1_axi_tb_master.md
# scr1_axi_tb_master

Single-outstanding AXI4 initiator for the SCR1 testbench. It converts a simple request/response command port into single-beat AXI transactions (awlen=arlen=0, INCR), which lets directed benches and BFMs drive any AXI memory or peripheral slave. It sits between the bench stimulus and the slave side of the AXI memory model, and is the initiator counterpart of that memory model.

## Interface
Parameters:
- W_ID, 4, AXI ID width
- W_ADR, 32, address width
- W_DATA, 32, data width (W_DATA/8 strobe bits)
- ID, 0, constant value driven on awid/arid
- TIMEOUT, 1024, cycles a transaction may stay on the bus before `timeout` is set

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  reset, asynchronous, active-high
- req_valid / req_ready  in/out  1  command handshake
- req_we  in  1  1 = write, 0 = read
- req_addr  in  W_ADR  byte address
- req_size  in  3  AXI size code (0..$clog2(W_DATA/8))
- req_wdata / req_wstrb  in  W_DATA / W_DATA/8  write payload, lane-aligned
- rsp_valid / rsp_ready  out/in  1  response handshake
- rsp_rdata  out  W_DATA  read data as captured from rdata, lane-aligned
- rsp_resp  out  2  bresp/rresp of the completed transaction
- rsp_err  out  1  ID mismatch, rlast=0, or resp != OKAY
- timeout  out  1  sticky; set when a transaction exceeds TIMEOUT cycles
- AW: awvalid out 1, awid out W_ID, awaddr out W_ADR, awsize out 3, awlen out 8, awready in 1
- W: wvalid out 1, wdata out W_DATA, wstrb out W_DATA/8, wlast out 1, wready in 1
- B: bvalid in 1, bid in W_ID, bresp in 2, bready out 1
- AR: arvalid out 1, arid out W_ID, araddr out W_ADR, arburst out 2, arsize out 3, arlen out 8, arready in 1
- R: rvalid in 1, rid in W_ID, rdata in W_DATA, rlast in 1, rresp in 2, rready out 1

## Operation
- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RSP.
- IDLE: req_ready=1. On req_valid, register the command, then go to WR_REQ (req_we=1) or RD_REQ.
- WR_REQ: awvalid and wvalid rise together. Each drops independently on its own handshake, and payloads stay stable until that handshake. Go to WR_RESP once both handshakes are done (same cycle allowed).
- WR_RESP: bready=1. On bvalid, capture bresp and check bid==ID, then go to RSP.
- RD_REQ: arvalid=1 until arready, then go to RD_DATA.
- RD_DATA: rready=1. On rvalid, capture rdata/rresp and check rid==ID and rlast=1, then go to RSP.
- RSP: rsp_valid=1, with outputs held stable until rsp_ready, then go to IDLE.
- Constant outputs: awlen=arlen=0, arburst=2'b01, wlast=wvalid, awid=arid=ID.
- Timeout counter: cleared in IDLE, counts every cycle in WR_*/RD_*, saturates at TIMEOUT. On reaching TIMEOUT it sets `timeout`, which is cleared only by rst. The transaction is never abandoned; the FSM keeps waiting.
- rsp_rdata = 0 for writes.

## Timing
- Reset values: all valids/readies = 0 except req_ready = 1; rsp_*, timeout = 0; addresses/data = 0; FSM = IDLE.
- Reset asserted mid-transaction drops all valids immediately (async). Slave state is the bench's concern.
- Request accepted at edge N → awvalid/wvalid/arvalid high from edge N+1.
- Zero-wait slave, write: AW/W handshake at N+1, bready from N+2, bvalid at N+2 → rsp_valid at N+3.
- Zero-wait slave, read: AR handshake at N+1, R at N+2 → rsp_valid at N+3.
- Back-to-back: rsp handshake at edge M → IDLE at M+1, so the next request is accepted no earlier than M+1.
- bvalid/rvalid arriving in the same cycle the address handshake completes is not possible by protocol and is ignored.

## Structure
- scr1_axi_tb_pkg: state enum, AXI resp constants (OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11), burst constant INCR.
- One sub-module, scr1_axi_tb_wdog: saturating TIMEOUT counter with clear/enable inputs and a sticky flag output.

## Test plan
- Write 0x0000_0100, size 2, data 0xDEADBEEF, strb 0xF, slave zero-wait → AW+W at N+1, rsp_valid at N+3, rsp_resp=0, rsp_err=0. A following read of 0x100 returns 0xDEADBEEF.
- awready held 0 for 3 cycles while wready=1 → W completes first with wvalid dropping; awaddr stays stable; B is accepted only after AW completes.
- Slave returns bid=ID+1 → rsp_err=1; rsp_resp equals the bresp driven.
- Read where the slave returns rresp=2'b10, rlast=1 → rsp_resp=2'b10, rsp_err=1.
- arready held 0 → timeout rises exactly TIMEOUT cycles after arvalid rises. Releasing arready then completes the read normally, with timeout still 1.
- rst pulse while in WR_RESP → all valids/readies 0 in that cycle, req_ready=1, and a new request is accepted after release.
